// File: rtl/icache_line_server_if.sv
// ============================================================================
//  icache_line_server_if : fetch-side and refill-side bundle for the line server
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface icache_line_server_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  abort;
   logic                  inv_all;
   logic                  req_ready;
   logic [127:0]          dout;
   logic                  dout_valid;
   logic                  mem_rd_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [127:0]          mem_rdata;
   logic                  mem_rdata_valid;

   modport master (
      output rd_en, addr, abort, inv_all, mem_rdata, mem_rdata_valid,
      input  req_ready, dout, dout_valid, mem_rd_req, mem_addr
   );

   modport slave (
      input  rd_en, addr, abort, inv_all, mem_rdata, mem_rdata_valid,
      output req_ready, dout, dout_valid, mem_rd_req, mem_addr
   );
endinterface

`default_nettype wire

// File: rtl/icache_line_server.sv
// ============================================================================
//  icache_line_server : direct-mapped read-only 128-bit line cache with refill
//  Revision: 1.0
// ============================================================================
`default_nettype none

module icache_line_server #(
   parameter int LINES      = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst_n,
   icache_line_server_if.slave   bus
);
   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = ADDR_WIDTH - IDX - 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_MISS       = 2'd1,
      ST_MISS_ABORT = 2'd2
   } state_t;

   state_t           r_state;
   logic [127:0]     r_data [LINES];
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [LINES-1:0] r_valid;
   logic [IDX-1:0]   r_miss_idx;
   logic [TAG_W-1:0] r_miss_tag;
   logic             r_req_ready;
   logic             r_dout_valid;
   logic [127:0]     r_dout;
   logic             r_mem_rd_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;

   logic [IDX-1:0]   w_idx;
   logic [TAG_W-1:0] w_tag;
   logic             w_hit;
   logic             w_take;
   logic             w_fill;
   logic             w_unused;

   assign w_idx    = bus.addr[IDX+3:4];
   assign w_tag    = bus.addr[ADDR_WIDTH-1:IDX+4];
   assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_take   = (r_state == ST_IDLE) && bus.rd_en && !bus.abort;
   // Only a pending refill may write the arrays; stray data in IDLE is dropped.
   assign w_fill   = (r_state != ST_IDLE) && bus.mem_rdata_valid;
   assign w_unused = ^bus.addr[3:0];

   assign bus.req_ready  = r_req_ready;
   assign bus.dout_valid = r_dout_valid;
   assign bus.dout       = r_dout;
   assign bus.mem_rd_req = r_mem_rd_req;
   assign bus.mem_addr   = r_mem_addr;

   always_ff @(posedge i_clk) begin
      if (w_fill) begin
         r_data[r_miss_idx] <= bus.mem_rdata;
         r_tag[r_miss_idx]  <= r_miss_tag;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_valid      <= '0;
         r_miss_idx   <= '0;
         r_miss_tag   <= '0;
         r_req_ready  <= 1'b1;
         r_dout_valid <= 1'b0;
         r_dout       <= '0;
         r_mem_rd_req <= 1'b0;
         r_mem_addr   <= '0;
      end else begin
         r_dout_valid <= 1'b0;

         // Invalidate-all wins over a fill landing in the same cycle.
         if (bus.inv_all)
            r_valid <= '0;
         else if (w_fill)
            r_valid[r_miss_idx] <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_miss_idx <= w_idx;
                  r_miss_tag <= w_tag;
                  if (w_hit) begin
                     r_dout_valid <= 1'b1;
                     r_dout       <= r_data[w_idx];
                  end else begin
                     r_mem_rd_req <= 1'b1;
                     r_mem_addr   <= {bus.addr[ADDR_WIDTH-1:4], 4'h0};
                     r_req_ready  <= 1'b0;
                     r_state      <= ST_MISS;
                  end
               end
            end
            ST_MISS: begin
               if (bus.mem_rdata_valid) begin
                  r_mem_rd_req <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
                  if (!bus.abort) begin
                     r_dout_valid <= 1'b1;
                     r_dout       <= bus.mem_rdata;
                  end
               end else if (bus.abort) begin
                  r_state <= ST_MISS_ABORT;
               end
            end
            ST_MISS_ABORT: begin
               // Memory cannot cancel, so the request stays up until the data arrives.
               if (bus.mem_rdata_valid) begin
                  r_mem_rd_req <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_mem_rd_req <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_icache_line_server.sv
// ============================================================================
//  tb_icache_line_server : directed scoreboard bench for icache_line_server
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_icache_line_server;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   icache_line_server_if #(.ADDR_WIDTH(32)) bus ();

   icache_line_server #(.LINES(16), .ADDR_WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   localparam logic [127:0] BASE = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   int total = 0;
   int bad   = 0;
   int exp_pulses = 0;
   int got_pulses = 0;
   logic [127:0] sb [$];

   function automatic logic [127:0] mem_line(input logic [31:0] a);
      logic [31:0] la;
      la = {a[31:4], 4'h0};
      if (la == 32'h100) return BASE;
      return BASE ^ {la, la ^ 32'h1, la ^ 32'h2, la ^ 32'h3};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Response monitor: every dout_valid pulse must match the oldest expected line.
   always @(negedge clk) begin : mon
      logic [127:0] e;
      if (rst_n && bus.dout_valid === 1'b1) begin
         got_pulses++;
         if (sb.size() == 0) begin
            check("unexpected_dout_valid", 128'd1, 128'd0);
         end else begin
            e = sb.pop_front();
            check("dout_data", bus.dout, e);
         end
      end
   end

   task automatic req_hit(input logic [31:0] a, input string tag);
      check({tag, "_ready"}, bus.req_ready, 1);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      sb.push_back(mem_line(a));
      exp_pulses++;
      @(negedge clk);
      bus.rd_en = 1'b0;
      check({tag, "_dv"}, bus.dout_valid, 1);
      check({tag, "_no_memreq"}, bus.mem_rd_req, 0);
   endtask

   task automatic req_miss(input logic [31:0] a, input int lat, input logic ab,
                           input logic inv, input string tag);
      logic [31:0] la;
      la = {a[31:4], 4'h0};
      check({tag, "_ready"}, bus.req_ready, 1);
      bus.rd_en = 1'b1;
      bus.addr  = a;
      if (!ab) begin
         sb.push_back(mem_line(a));
         exp_pulses++;
      end
      @(negedge clk);
      bus.rd_en = 1'b0;
      check({tag, "_memreq"}, bus.mem_rd_req, 1);
      check({tag, "_memaddr"}, bus.mem_addr, la);
      check({tag, "_busy"}, bus.req_ready, 0);
      check({tag, "_no_early_dv"}, bus.dout_valid, 0);
      repeat (lat) @(negedge clk);
      if (lat > 0) check({tag, "_memreq_held"}, bus.mem_rd_req, 1);
      bus.mem_rdata       = mem_line(a);
      bus.mem_rdata_valid = 1'b1;
      bus.abort           = ab;
      bus.inv_all         = inv;
      @(negedge clk);
      bus.mem_rdata_valid = 1'b0;
      bus.abort           = 1'b0;
      bus.inv_all         = 1'b0;
      check({tag, "_memreq_drop"}, bus.mem_rd_req, 0);
      check({tag, "_ready_back"}, bus.req_ready, 1);
      check({tag, "_dv"}, bus.dout_valid, {127'd0, ~ab});
   endtask

   initial begin : main
      logic [31:0] seq [3];
      bus.rd_en           = 1'b0;
      bus.addr            = '0;
      bus.abort           = 1'b0;
      bus.inv_all         = 1'b0;
      bus.mem_rdata       = '0;
      bus.mem_rdata_valid = 1'b0;

      repeat (2) @(negedge clk);
      check("rst_ready", bus.req_ready, 1);
      check("rst_dv", bus.dout_valid, 0);
      check("rst_memreq", bus.mem_rd_req, 0);
      check("rst_dout", bus.dout, 0);
      check("rst_memaddr", bus.mem_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);

      req_miss(32'h100, 2, 1'b0, 1'b0, "cold_100");
      check("cold_100_data", bus.dout, BASE);
      req_hit(32'h108, "hit_108");
      req_miss(32'h110, 1, 1'b0, 1'b0, "cold_110");

      seq[0] = 32'h100; seq[1] = 32'h110; seq[2] = 32'h104;
      for (int i = 0; i < 3; i++) begin
         check("b2b_ready", bus.req_ready, 1);
         bus.rd_en = 1'b1;
         bus.addr  = seq[i];
         sb.push_back(mem_line(seq[i]));
         exp_pulses++;
         @(negedge clk);
         check("b2b_dv", bus.dout_valid, 1);
      end
      bus.rd_en = 1'b0;
      check("b2b_no_memreq", bus.mem_rd_req, 0);

      // Miss on 0x200 aborted two cycles in; refill still completes silently.
      bus.rd_en = 1'b1;
      bus.addr  = 32'h200;
      @(negedge clk);
      bus.rd_en = 1'b0;
      check("abt_memreq", bus.mem_rd_req, 1);
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abt_memreq_held", bus.mem_rd_req, 1);
      check("abt_busy", bus.req_ready, 0);
      repeat (2) @(negedge clk);
      check("abt_memreq_held2", bus.mem_rd_req, 1);
      bus.mem_rdata       = mem_line(32'h200);
      bus.mem_rdata_valid = 1'b1;
      @(negedge clk);
      bus.mem_rdata_valid = 1'b0;
      check("abt_no_dv", bus.dout_valid, 0);
      check("abt_memreq_drop", bus.mem_rd_req, 0);
      check("abt_ready", bus.req_ready, 1);
      check("abt_dout_hold", bus.dout, BASE);
      req_hit(32'h200, "abt_refill_hit");

      req_miss(32'h100, 0, 1'b0, 1'b0, "evict_100");
      req_miss(32'h200, 3, 1'b0, 1'b0, "evict_200");
      req_miss(32'h100, 1, 1'b0, 1'b0, "evict_100b");

      // abort alongside rd_en: neither a resident hit nor a miss is taken.
      bus.rd_en = 1'b1; bus.abort = 1'b1; bus.addr = 32'h100;
      @(negedge clk);
      check("rdabt_hit_no_dv", bus.dout_valid, 0);
      bus.addr = 32'h500;
      @(negedge clk);
      bus.rd_en = 1'b0; bus.abort = 1'b0;
      check("rdabt_miss_no_memreq", bus.mem_rd_req, 0);
      check("rdabt_ready", bus.req_ready, 1);

      req_miss(32'h140, 2, 1'b1, 1'b0, "abt_fill_same");
      req_hit(32'h140, "abt_fill_hit");

      req_miss(32'h120, 1, 1'b0, 1'b1, "inv_fill");
      req_miss(32'h120, 0, 1'b0, 1'b0, "inv_fill_remiss");

      req_miss(32'h100, 1, 1'b0, 1'b0, "pre_inv");
      req_hit(32'h100, "pre_inv_hit");
      bus.inv_all = 1'b1;
      @(negedge clk);
      bus.inv_all = 1'b0;
      req_miss(32'h100, 1, 1'b0, 1'b0, "post_inv");

      // Asynchronous reset in the middle of a refill.
      bus.rd_en = 1'b1;
      bus.addr  = 32'h300;
      @(negedge clk);
      bus.rd_en = 1'b0;
      check("rstmiss_memreq", bus.mem_rd_req, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmiss_ready", bus.req_ready, 1);
      check("rstmiss_memreq", bus.mem_rd_req, 0);
      check("rstmiss_dv", bus.dout_valid, 0);
      check("rstmiss_dout", bus.dout, 0);
      check("rstmiss_memaddr", bus.mem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_rdata       = mem_line(32'h300);
      bus.mem_rdata_valid = 1'b1;
      @(negedge clk);
      bus.mem_rdata_valid = 1'b0;
      check("rst_stray_no_dv", bus.dout_valid, 0);
      check("rst_stray_no_memreq", bus.mem_rd_req, 0);
      req_miss(32'h100, 1, 1'b0, 1'b0, "post_rst");

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      check("pulse_count", got_pulses, exp_pulses);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #50000;
      bad++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
